boot_irq_sequencer: RTL and testbench
=====================================

Name: boot_irq_sequencer

Overview:
- Sits directly upstream of the accumulator processor top level.
- Converts one asynchronous active-low board reset into the core's two-phase start sequence: a StartEverything pulse, a gap, then a secondstagereset pulse.
- Also synchronises, edge-detects and latches an external interrupt request. It presents the request to the core's interrupt input only once boot is complete, and holds it until the core acknowledges.

Parameters:
- START_CYCLES, 2: cycles StartEverything stays high after reset release or after boot_req (min 1).
- GAP_CYCLES, 3: low cycles between the end of StartEverything and the start of secondstagereset (min 1).
- SECOND_CYCLES, 1: cycles secondstagereset stays high (min 1).
- SYNC_STAGES, 2: flip-flop stages in the irq_in synchroniser (min 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- boot_req  input  1  synchronous request to re-run the boot sequence; honoured only in RUN.
- irq_in  input  1  asynchronous external interrupt request, level; the rising edge is the event.
- irq_ack  input  1  synchronous one-cycle acknowledge from the core.
- StartEverything  output  1  first-stage core reset/start.
- secondstagereset  output  1  second-stage core reset.
- interrupt  output  1  latched interrupt to the core.
- boot_done  output  1  high while in RUN.

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n.
- While rst_n is low, all state is cleared:
  - StartEverything=1, so the core is held;
  - secondstagereset=0, interrupt=0, boot_done=0;
  - state=START, counter=START_CYCLES-1;
  - synchroniser flops=0, edge-detect history=0, latch=0.
- FSM states are START, GAP, SECOND and RUN. All outputs are registered and decoded from state:
  - START: StartEverything=1. Counter decrements each edge; at 0 the FSM goes to GAP and the counter loads GAP_CYCLES-1.
  - GAP: all outputs low. At counter 0 it goes to SECOND and the counter loads SECOND_CYCLES-1.
  - SECOND: secondstagereset=1. At counter 0 it goes to RUN.
  - RUN: boot_done=1. On boot_req=1 it goes to START and the counter loads START_CYCLES-1. The latch clears the same edge.
- boot_req is ignored outside RUN.
- Counter width is $clog2 of the largest parameter, with a minimum of 1 bit.
- With defaults, after rst_n deasserts:
  - StartEverything stays high through the 2nd rising edge and goes low after it;
  - secondstagereset is high after edge 5 and low after edge 6;
  - boot_done=1 after edge 6.
- Interrupt path:
  - irq_in passes through SYNC_STAGES flops.
  - Rising edge = (sync_out & ~sync_prev).
  - In RUN, an edge sets the latch; interrupt = latch.
  - irq_ack=1 clears the latch. If an edge and irq_ack arrive in the same cycle, the latch remains set (the new event wins).
  - Edges outside RUN are dropped; they are not held pending.
  - Latency: if irq_in is high before edge k, interrupt is high after edge k+SYNC_STAGES (defaults: after edge k+2).
  - A level held high generates one event only.
  - irq_ack with the latch clear has no effect.
- Reset mid-operation: asserting rst_n in any state forces the reset values immediately (asynchronous) and restarts the sequence from START on release.

Optional Feature:
- Macro BOOT_IRQ_DROP_COUNT_EN.
- Defined:
  - adds output irq_dropped [7:0], an 8-bit counter of edges dropped outside RUN;
  - the counter saturates at 255 and resets to 0 only on rst_n;
  - edges arriving while the latch is already set also count as dropped.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package boot_irq_pkg holds:
  - the state enum (START=2'd0, GAP=2'd1, SECOND=2'd2, RUN=2'd3);
  - the default parameter constants;
  - a function computing the counter width.
- One natural sub-module, irq_sync_edge: the SYNC_STAGES synchroniser plus rising-edge detector. It is instantiated once.

Test Plan:
- Power-up with defaults: rst_n low for 3 cycles, then high.
  - Required: StartEverything=1 during reset and for 2 edges, then 0 for 3 cycles.
  - secondstagereset=1 for 1 cycle.
  - boot_done=1 after edge 6 and stays high.
- Interrupt in RUN: pulse irq_in high for 5 cycles.
  - Required: interrupt rises 2 edges later and stays high.
  - irq_ack one cycle later clears it on the next edge; there is no second event.
- Simultaneous edge and irq_ack:
  - Latch set, new irq_in edge, then irq_ack in the cycle the edge is detected.
  - Required: interrupt remains 1.
  - A second irq_ack clears it.
- Dropped edge: irq_in rising during GAP.
  - Required: interrupt stays 0 through boot and after boot_done.
  - With BOOT_IRQ_DROP_COUNT_EN, irq_dropped=1.
- Re-boot: boot_req in RUN with the latch set.
  - Required: latch clears and boot_done=0 on the next edge.
  - Full 2/3/1 sequence repeats; boot_req asserted during GAP is ignored.
- Mid-sequence reset: assert rst_n low during SECOND.
  - Required: secondstagereset=0 and StartEverything=1 with no clock edge.
  - Sequence restarts cleanly on release.
  - With the feature enabled, 300 dropped edges give irq_dropped=255.

Source files
------------

// File: rtl/boot_irq_pkg.sv
// ---------------------------------------------------------------------------
// boot_irq_pkg
// Shared definitions for the boot / interrupt sequencer that sits in front of
// the accumulator processor core.
//   - boot_state_e : sequencer states (START, GAP, SECOND, RUN)
//   - DEF_*        : default timing parameters
//   - cnt_width()  : width of the phase counter for a given parameter set
// Optional feature macro used by this slice: BOOT_IRQ_DROP_COUNT_EN
// ---------------------------------------------------------------------------
package boot_irq_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        GAP    = 2'd1,
        SECOND = 2'd2,
        RUN    = 2'd3
    } boot_state_e;

    localparam int DEF_START_CYCLES  = 2;
    localparam int DEF_GAP_CYCLES    = 3;
    localparam int DEF_SECOND_CYCLES = 1;
    localparam int DEF_SYNC_STAGES   = 2;

    // The counter only ever holds (cycles - 1), so $clog2 of the largest
    // phase length is enough; a phase length of 1 still needs one bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if ($clog2(m) < 1) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// ---------------------------------------------------------------------------
// irq_sync_edge
// Brings an asynchronous level into the clk domain through SYNC_STAGES flops
// and produces a one-cycle pulse on each rising edge of the synchronised level.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset (clears all flops)
//   async_in in  asynchronous level input
//   rise     out high for one cycle after a 0->1 transition of the synced level
// ---------------------------------------------------------------------------
module irq_sync_edge
    import boot_irq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // prev_q is the synchroniser output one cycle earlier, so a held-high
    // level produces exactly one pulse.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/boot_irq_sequencer.sv
// ---------------------------------------------------------------------------
// boot_irq_sequencer
// Turns the board reset into the core's two-phase start sequence
// (StartEverything pulse, low gap, secondstagereset pulse) and gates a
// synchronised, edge-detected, latched interrupt to the core once boot is done.
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   boot_req         in   re-run the boot sequence (honoured only in RUN)
//   irq_in           in   asynchronous interrupt level, rising edge is the event
//   irq_ack          in   one-cycle acknowledge from the core, clears the latch
//   StartEverything  out  first-stage core start/reset (high in START)
//   secondstagereset out  second-stage core reset (high in SECOND)
//   interrupt        out  latched interrupt request
//   boot_done        out  high while in RUN
//   irq_dropped      out  [7:0] saturating count of dropped edges
//                         (only when BOOT_IRQ_DROP_COUNT_EN is defined)
// ---------------------------------------------------------------------------
module boot_irq_sequencer
    import boot_irq_pkg::*;
#(
    parameter int START_CYCLES  = DEF_START_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int SECOND_CYCLES = DEF_SECOND_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boot_req,
    input  logic       irq_in,
    input  logic       irq_ack,
    output logic       StartEverything,
    output logic       secondstagereset,
    output logic       interrupt,
    output logic       boot_done
`ifdef BOOT_IRQ_DROP_COUNT_EN
    ,
    output logic [7:0] irq_dropped
`endif
);

    localparam int CNT_W = cnt_width(START_CYCLES, GAP_CYCLES, SECOND_CYCLES);

    localparam logic [CNT_W-1:0] START_LOAD  = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SECOND_LOAD = CNT_W'(SECOND_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    boot_state_e      state_q;
    boot_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             latch_q;
    logic             latch_d;
    logic             irq_rise;
    logic             in_run;

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (irq_in),
        .rise     (irq_rise)
    );

    assign in_run = (state_q == RUN);

    // Phase sequencing: each timed phase counts down from (length - 1) and
    // advances when the counter reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            START: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = SECOND;
                    cnt_d   = SECOND_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SECOND: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (boot_req) begin
                    state_d = START;
                    cnt_d   = START_LOAD;
                end
            end
            default: begin
                state_d = START;
                cnt_d   = START_LOAD;
            end
        endcase
    end

    // Re-boot clears the latch; otherwise a new edge beats a same-cycle ack.
    // Edges outside RUN never set the latch, so nothing is held pending.
    always_comb begin
        latch_d = latch_q;
        if (in_run && boot_req) begin
            latch_d = 1'b0;
        end else if (in_run && irq_rise) begin
            latch_d = 1'b1;
        end else if (irq_ack) begin
            latch_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START;
            cnt_q   <= START_LOAD;
            latch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
        end
    end

`ifdef BOOT_IRQ_DROP_COUNT_EN
    logic [7:0] drop_q;
    logic [7:0] drop_d;

    // An edge is lost either because boot is not finished or because the
    // previous event has not been acknowledged yet.
    always_comb begin
        drop_d = drop_q;
        if (irq_rise && (!in_run || latch_q) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign irq_dropped = drop_q;
`endif

    assign StartEverything  = (state_q == START);
    assign secondstagereset = (state_q == SECOND);
    assign boot_done        = in_run;
    assign interrupt        = latch_q;

endmodule

// File: tb/tb_boot_irq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_boot_irq_sequencer
// Scoreboard bench for boot_irq_sequencer. A behavioural model pushes the
// expected outputs after every rising edge; a monitor pops and compares them
// shortly after the edge. Honours BOOT_IRQ_DROP_COUNT_EN for irq_dropped.
// ---------------------------------------------------------------------------
module tb_boot_irq_sequencer;

    localparam int S_CYC  = 2;
    localparam int G_CYC  = 3;
    localparam int SEC_CYC = 1;
    localparam int SYNC   = 2;
    localparam int TOTAL  = S_CYC + G_CYC + SEC_CYC;

    typedef struct packed {
        logic       se;
        logic       ssr;
        logic       intr;
        logic       done;
        logic [7:0] drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boot_req = 1'b0;
    logic irq_in = 1'b0;
    logic irq_ack = 1'b0;
    logic StartEverything;
    logic secondstagereset;
    logic interrupt;
    logic boot_done;
`ifdef BOOT_IRQ_DROP_COUNT_EN
    logic [7:0] irq_dropped;
`endif

    int checks = 0;
    int failures = 0;
    int cycle_no = 0;

    exp_t exp_q[$];

    // Model state: edges elapsed since the current boot started, the pending
    // interrupt flag, the dropped-edge tally and the recent irq_in samples.
    int boot_e = 0;
    bit model_latch = 1'b0;
    int model_drop = 0;
    bit samp[$] = '{0, 0, 0, 0};

    boot_irq_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .boot_req         (boot_req),
        .irq_in           (irq_in),
        .irq_ack          (irq_ack),
        .StartEverything  (StartEverything),
        .secondstagereset (secondstagereset),
        .interrupt        (interrupt),
        .boot_done        (boot_done)
`ifdef BOOT_IRQ_DROP_COUNT_EN
        ,
        .irq_dropped      (irq_dropped)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compare every DUT output against one expected record.
    task automatic checkOutput(input exp_t e, input string tag);
        checks++;
        if (StartEverything !== e.se) begin
            failures++;
            $display("[TB] FAIL %s StartEverything got=%0b exp=%0b (cycle %0d)", tag, StartEverything, e.se, cycle_no);
        end
        checks++;
        if (secondstagereset !== e.ssr) begin
            failures++;
            $display("[TB] FAIL %s secondstagereset got=%0b exp=%0b (cycle %0d)", tag, secondstagereset, e.ssr, cycle_no);
        end
        checks++;
        if (interrupt !== e.intr) begin
            failures++;
            $display("[TB] FAIL %s interrupt got=%0b exp=%0b (cycle %0d)", tag, interrupt, e.intr, cycle_no);
        end
        checks++;
        if (boot_done !== e.done) begin
            failures++;
            $display("[TB] FAIL %s boot_done got=%0b exp=%0b (cycle %0d)", tag, boot_done, e.done, cycle_no);
        end
`ifdef BOOT_IRQ_DROP_COUNT_EN
        checks++;
        if (irq_dropped !== e.drop) begin
            failures++;
            $display("[TB] FAIL %s irq_dropped got=%0d exp=%0d (cycle %0d)", tag, irq_dropped, e.drop, cycle_no);
        end
`endif
    endtask

    // Drive the three synchronous inputs for n cycles, changing on negedges.
    task automatic applyStimulus(input bit br, input bit ir, input bit ack, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            boot_req = br;
            irq_in   = ir;
            irq_ack  = ack;
        end
    endtask

    // Reference model: the boot sequence is a count of edges since boot start
    // compared against the phase lengths; an interrupt event is a 0->1 change
    // in irq_in as seen SYNC edges ago.
    always @(posedge clk) begin
        exp_t e;
        bit run_before;
        bit ev;
        cycle_no++;
        if (!rst_n) begin
            boot_e = 0;
            model_latch = 1'b0;
            model_drop = 0;
            samp = '{0, 0, 0, 0};
        end else begin
            run_before = (boot_e >= TOTAL);
            samp.push_front(irq_in);
            void'(samp.pop_back());
            ev = samp[SYNC] && !samp[SYNC+1];
            if (ev && (!run_before || model_latch) && model_drop < 255) model_drop++;
            if (run_before && boot_req) model_latch = 1'b0;
            else if (run_before && ev) model_latch = 1'b1;
            else if (irq_ack) model_latch = 1'b0;
            if (run_before && boot_req) boot_e = 0;
            else if (boot_e < TOTAL) boot_e++;
        end
        e.se   = (boot_e < S_CYC);
        e.ssr  = (boot_e >= S_CYC + G_CYC) && (boot_e < TOTAL);
        e.done = (boot_e >= TOTAL);
        e.intr = model_latch;
        e.drop = 8'(model_drop);
        exp_q.push_back(e);
    end

    // Monitor: shortly after each edge pop the expectation and compare.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty got=0 entries exp>=1 (cycle %0d)", cycle_no);
        end else begin
            checkOutput(exp_q.pop_front(), "edge");
        end
    end

    // Directed scenarios followed by a randomized run and a dropped-edge storm.
    initial begin
        exp_t rst_exp;
        bit ir;
        rst_exp = '{se: 1'b1, ssr: 1'b0, intr: 1'b0, done: 1'b0, drop: 8'd0};

        #1;
        checkOutput(rst_exp, "power_on_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // irq edge during GAP must be dropped, level held through boot
        applyStimulus(0, 0, 0, 2);
        applyStimulus(0, 1, 0, 12);
        applyStimulus(0, 0, 0, 4);

        // interrupt in RUN, then acknowledge
        applyStimulus(0, 1, 0, 5);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 4);

        // new edge and ack in the same cycle: latch stays, second ack clears
        applyStimulus(0, 1, 0, 4);
        applyStimulus(0, 0, 0, 3);
        applyStimulus(0, 1, 0, 2);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 3);

        // re-boot with latch set; boot_req during GAP ignored
        applyStimulus(0, 1, 0, 4);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 1, 0, 3);
        applyStimulus(1, 0, 0, 2);
        applyStimulus(0, 0, 0, 8);

        // asynchronous reset in the middle of SECOND
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput(rst_exp, "async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput(rst_exp, "reset_in_second");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 8);

        // randomized traffic
        ir = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) ir = ~ir;
            applyStimulus(($urandom_range(0, 63) == 0), ir, ($urandom_range(0, 7) == 0), 1);
        end

        // dropped-edge storm with latch held
        applyStimulus(0, 0, 0, 8);
        applyStimulus(0, 1, 0, 4);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 0, 1);
            applyStimulus(0, 1, 0, 1);
        end
        applyStimulus(0, 0, 0, 4);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
